// File: rtl/pkt_merger.sv
// rtl/pkt_merger.sv - round-robin merge of NUM_INPUTS packet streams into one registered output
// Optional macro PKT_MERGE_CNT_EN enables the per-input accepted-packet pulses on cnt_out.
module pkt_merger #(
  parameter int PKT_BITS   = 72,
  parameter int NUM_INPUTS = 4,
  parameter int SRC_BITS   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] en_in,
  input  logic [PKT_BITS-1:0]   pkt_in_data_in [NUM_INPUTS],
  input  logic                  pkt_in_vld_in  [NUM_INPUTS],
  output logic                  pkt_in_rdy_out [NUM_INPUTS],
  output logic [PKT_BITS-1:0]   pkt_out_data_out,
  output logic [SRC_BITS-1:0]   pkt_out_src_out,
  output logic                  pkt_out_vld_out,
  input  logic                  pkt_out_rdy_in,
  output logic [NUM_INPUTS-1:0] cnt_out
);

  logic [NUM_INPUTS-1:0] req;
  logic [SRC_BITS-1:0]   last;
  logic [SRC_BITS-1:0]   gnt;
  logic                  gnt_vld;
  logic                  load;
  logic                  in_xfer;

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      req[i] = pkt_in_vld_in[i] && en_in[i];
    end
  end

  // Search starts just after the last winner so every requester waits at most NUM_INPUTS-1 grants.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      if (!gnt_vld && req[(int'(last) + k) % NUM_INPUTS]) begin
        gnt_vld = 1'b1;
        gnt     = SRC_BITS'((int'(last) + k) % NUM_INPUTS);
      end
    end
  end

  // Reset masks ready so nothing is taken upstream while the output stage is being cleared.
  assign load    = (!pkt_out_vld_out || pkt_out_rdy_in) && !reset;
  assign in_xfer = load && gnt_vld;

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      pkt_in_rdy_out[i] = in_xfer && (gnt == SRC_BITS'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_out_vld_out  <= 1'b0;
      pkt_out_data_out <= '0;
      pkt_out_src_out  <= '0;
      last             <= SRC_BITS'(NUM_INPUTS - 1);
    end else if (in_xfer) begin
      pkt_out_vld_out  <= 1'b1;
      pkt_out_data_out <= pkt_in_data_in[gnt];
      pkt_out_src_out  <= gnt;
      last             <= gnt;
    end else if (pkt_out_rdy_in) begin
      pkt_out_vld_out  <= 1'b0;
    end
  end

`ifdef PKT_MERGE_CNT_EN
  logic [NUM_INPUTS-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (in_xfer) begin
      cnt_q <= NUM_INPUTS'(1) << gnt;
    end else begin
      cnt_q <= '0;
    end
  end

  assign cnt_out = cnt_q;
`else
  assign cnt_out = '0;
`endif

endmodule

// File: tb/tb_pkt_merger.sv
// tb/tb_pkt_merger.sv - directed table, corner sequences and randomized model check for pkt_merger
module tb_pkt_merger;
  localparam int N  = 4;
  localparam int W  = 72;
  localparam int SB = 2;
`ifdef PKT_MERGE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  en;
  logic [W-1:0]  din [N];
  logic          vin [N];
  logic          rdy [N];
  logic [W-1:0]  dout;
  logic [SB-1:0] src;
  logic          vout;
  logic          rin;
  logic [N-1:0]  cnt;

  always #5 clk = ~clk;

  pkt_merger #(.PKT_BITS(W), .NUM_INPUTS(N)) dut (
    .clk(clk), .reset(reset), .en_in(en),
    .pkt_in_data_in(din), .pkt_in_vld_in(vin), .pkt_in_rdy_out(rdy),
    .pkt_out_data_out(dout), .pkt_out_src_out(src), .pkt_out_vld_out(vout),
    .pkt_out_rdy_in(rin), .cnt_out(cnt)
  );

  int checks = 0;
  int errors = 0;

  logic         m_vld;
  logic [W-1:0] m_data;
  int           m_src;
  int           m_last;
  logic [N-1:0] m_cnt;
  int           last_xfer;

  typedef struct {
    logic [N-1:0] vld;
    logic         rin;
    logic         ev;
    logic [1:0]   esrc;
    logic [N-1:0] erdy;
    logic [N-1:0] ecnt;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pdata(input int i);
    return {8'hA5, 32'h1000_0000 + i, 24'h0, 8'(i)};
  endfunction

  function automatic logic [N-1:0] rdy_vec();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = rdy[i];
    return r;
  endfunction

  // Next winner: first enabled requester scanning forward from the last winner.
  function automatic int pick();
    for (int k = 1; k <= N; k++) begin
      if (vin[(m_last + k) % N] && en[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_rdy();
    int g;
    if (reset) return '0;
    g = pick();
    if ((!m_vld || rin) && g >= 0) return N'(1) << g;
    return '0;
  endfunction

  task automatic model_reset();
    m_vld = 1'b0; m_data = '0; m_src = 0; m_last = N - 1; m_cnt = '0; last_xfer = -1;
  endtask

  task automatic model_step();
    int g;
    bit x;
    if (reset) begin
      model_reset();
    end else begin
      g = pick();
      x = (!m_vld || rin) && (g >= 0);
      m_cnt = (CNT_ON && x) ? N'(1) << g : '0;
      last_xfer = x ? g : -1;
      if (x) begin
        m_vld = 1'b1; m_data = din[g]; m_src = g; m_last = g;
      end else if (rin) begin
        m_vld = 1'b0;
      end
    end
  endtask

  task automatic tick();
    #1;
    chk("m_vld",  vout, m_vld);
    chk("m_src",  src, m_src[SB-1:0]);
    chk("m_data", dout, m_data);
    chk("m_cnt",  cnt, m_cnt);
    chk("m_rdy",  rdy_vec(), exp_rdy());
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    int n;
    bit seen2;
    reset = 1'b1; rin = 1'b0; en = '1;
    for (int i = 0; i < N; i++) begin vin[i] = 1'b0; din[i] = pdata(i); end
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    chk("rst_vld", vout, 0);
    chk("rst_src", src, 0);
    chk("rst_data", dout, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_rdy", rdy_vec(), 0);
    reset = 1'b0;

    //         vld      rin   ev    esrc   erdy     ecnt
    tbl[0]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0001, 4'b0000};
    tbl[1]  = '{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0010, 4'b0001};
    tbl[2]  = '{4'b1111, 1'b1, 1'b1, 2'd1, 4'b0100, 4'b0010};
    tbl[3]  = '{4'b1111, 1'b1, 1'b1, 2'd2, 4'b1000, 4'b0100};
    tbl[4]  = '{4'b1111, 1'b1, 1'b1, 2'd3, 4'b0001, 4'b1000};
    tbl[5]  = '{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0010, 4'b0001};
    tbl[6]  = '{4'b1001, 1'b0, 1'b1, 2'd1, 4'b0000, 4'b0010};
    tbl[7]  = '{4'b1001, 1'b0, 1'b1, 2'd1, 4'b0000, 4'b0000};
    tbl[8]  = '{4'b1001, 1'b1, 1'b1, 2'd1, 4'b1000, 4'b0000};
    tbl[9]  = '{4'b1001, 1'b1, 1'b1, 2'd3, 4'b0001, 4'b1000};
    tbl[10] = '{4'b0000, 1'b1, 1'b1, 2'd0, 4'b0000, 4'b0001};
    tbl[11] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000};

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < N; i++) vin[i] = tbl[r].vld[i];
      rin = tbl[r].rin;
      #1;
      chk($sformatf("tbl%0d_vld", r), vout, tbl[r].ev);
      chk($sformatf("tbl%0d_src", r), src, tbl[r].esrc);
      chk($sformatf("tbl%0d_rdy", r), rdy_vec(), tbl[r].erdy);
      chk($sformatf("tbl%0d_cnt", r), cnt, CNT_ON ? tbl[r].ecnt : 4'b0000);
      if (tbl[r].ev) chk($sformatf("tbl%0d_data", r), dout, pdata(int'(tbl[r].esrc)));
      tick();
    end

    // Single active input keeps winning.
    for (int i = 0; i < N; i++) vin[i] = (i == 2);
    din[2] = 72'h0A_DEADBEEF_55;
    rin = 1'b1;
    tick();
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("solo_src", src, 2);
      chk("solo_data", dout, 72'h0A_DEADBEEF_55);
      chk("solo_rdy", rdy_vec(), 4'b0100);
      tick();
    end

    // Disabled input is never granted, then served soon after re-enable.
    for (int i = 0; i < N; i++) begin vin[i] = 1'b1; din[i] = pdata(i); end
    en = 4'b1011;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("dis_rdy2", rdy[2], 0);
      tick();
    end
    en = 4'b1111;
    n = 0; seen2 = 0;
    for (int c = 0; c < 8 && !seen2; c++) begin
      #1;
      if (rdy[2]) seen2 = 1;
      else if (rdy_vec() != 0) n++;
      tick();
    end
    chk("reen_granted", seen2, 1);
    chk("reen_wait_le3", n <= 3, 1);

    // Reset while the output register holds a packet.
    tick(); tick();
    chk("pre_rst_vld", vout, 1);
    reset = 1'b1;
    #1;
    chk("in_rst_rdy", rdy_vec(), 0);
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_vld", vout, 0);
    chk("post_rst_src", src, 0);
    chk("post_rst_cnt", cnt, 0);
    chk("post_rst_gnt0", rdy_vec(), 4'b0001);
    tick();

    // Randomized traffic against the reference model, holding pending packets stable.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!vin[i] || last_xfer == i) begin
          vin[i] = ($urandom_range(0, 3) != 0);
          din[i] = {8'($urandom), $urandom, $urandom};
        end
      end
      rin = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) en = N'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
